mips_regfile_mp: RTL and testbench
==================================

MIPS_REGFILE_MP -- requirements
Module: mips_regfile_mp

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, register word width in bits.
REQ-002 SHALL provide parameter DEPTH, default 32, number of registers (2..256).
REQ-003 SHALL provide parameter ADDR_W, default 5, address width; DEPTH <= 2**ADDR_W.
REQ-004 SHALL provide parameter ZERO_REG, default 1; 1 = register 0 hardwired to zero.
REQ-005 SHALL provide parameter BYPASS, default 1; 1 = same-edge write data forwarded to read outputs.
REQ-006 One clock; reset is asynchronous and active-low.
REQ-007 clk  input  1  rising-edge clock for all state.
REQ-008 rst_n  input  1  asynchronous active-low reset.
REQ-009 re1  input  1  read enable, port 1.
REQ-010 ra1  input  ADDR_W  read address, port 1.
REQ-011 rd1  output  DATA_W  registered read data, port 1.
REQ-012 re2  input  1  read enable, port 2.
REQ-013 ra2  input  ADDR_W  read address, port 2.
REQ-014 rd2  output  DATA_W  registered read data, port 2.
REQ-015 we_a  input  1  write enable, port A (older instruction).
REQ-016 wa_a  input  ADDR_W  write address, port A.
REQ-017 wd_a  input  DATA_W  write data, port A.
REQ-018 we_b  input  1  write enable, port B (younger instruction).
REQ-019 wa_b  input  ADDR_W  write address, port B.
REQ-020 wd_b  input  DATA_W  write data, port B.

Function
REQ-021 Storage SHALL be DEPTH words of DATA_W bits; no initialisation from file.
REQ-022 Writes SHALL occur at rising clk when we_x=1, rst_n=1 and wa_x < DEPTH; addresses >= DEPTH silently dropped.
REQ-023 With ZERO_REG=1, writes to address 0 SHALL be discarded; with ZERO_REG=0, register 0 is ordinary.
REQ-024 Both write ports to the same address on the same edge: port B data SHALL be stored, port A discarded.
REQ-025 Distinct write addresses on the same edge SHALL both be stored.
REQ-026 Reads SHALL have 1-cycle latency: at rising clk with re_x=1, rd_x loads the value of register ra_x.
REQ-027 re_x=0 SHALL hold rd_x unchanged, even if the addressed register is written.
REQ-028 Read address >= DEPTH SHALL load 0; with ZERO_REG=1, read of address 0 SHALL load 0.
REQ-029 BYPASS=1: if a write to ra_x commits on the same edge, rd_x SHALL load the write data (port B over port A per REQ-024), never the stale value.
REQ-030 BYPASS=0: same-edge read-write collision SHALL load the pre-write value.
REQ-031 Bypass SHALL never forward a discarded write (address 0 with ZERO_REG=1, address >= DEPTH).
REQ-032 Both read ports SHALL operate independently; same address on both ports returns identical data.

Reset
REQ-033 rst_n low SHALL immediately clear all registers, rd1 and rd2 to 0, regardless of clk.
REQ-034 Writes and reads on edges while rst_n is low SHALL be ignored; a write coincident with assertion is lost.
REQ-035 First rising clk with rst_n high SHALL perform normal read/write operation.

Verification
REQ-036 Reset, then we_a=1 wa_a=5 wd_a=0xDEADBEEF; next edge re1=1 ra1=5 -> rd1=0xDEADBEEF one cycle later.
REQ-037 Same edge: we_a wa_a=7 wd_a=0x11, we_b wa_b=7 wd_b=0x22, re1 ra1=7 -> BYPASS=1: rd1=0x22; later read of 7 -> 0x22.
REQ-038 ZERO_REG=1: we_b wa_b=0 wd_b=0xFFFFFFFF, same-edge re2 ra2=0 -> rd2=0; later read of 0 -> 0.
REQ-039 Write reg 3=0xA5, re1=0 ra1=3 -> rd1 holds previous value; BYPASS=0 collision read of 3 with write 0x5A -> rd1=0xA5.
REQ-040 Fill regs 1..31 with index value, pulse rst_n low mid-cycle -> rd1=rd2=0 at once; reads of all registers -> 0.
REQ-041 DEPTH=16 ADDR_W=5: write 0x33 to addr 20 -> dropped; read addr 20 -> 0; regs 0..15 unchanged.

Source files
------------

// File: rtl/mips_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : mips_regfile_mp
// Brief    : Dual-read / dual-write register file with registered reads,
//            optional hardwired-zero register 0 and same-edge write bypass.
// Revision : 1.0
// ============================================================================
module mips_regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              re1,
  input  logic [ADDR_W-1:0] ra1,
  output logic [DATA_W-1:0] rd1,
  input  logic              re2,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd2,
  input  logic              we_a,
  input  logic [ADDR_W-1:0] wa_a,
  input  logic [DATA_W-1:0] wd_a,
  input  logic              we_b,
  input  logic [ADDR_W-1:0] wa_b,
  input  logic [DATA_W-1:0] wd_b
);

  localparam logic [ADDR_W:0] c_DEPTH = (ADDR_W+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic              w_cmt_a;
  logic              w_cmt_b;
  logic [DATA_W-1:0] w_rd1;
  logic [DATA_W-1:0] w_rd2;

  // A write "commits" only if it will really land in storage; bypass uses the same qualifier.
  assign w_cmt_a = we_a && ({1'b0, wa_a} < c_DEPTH) && !((ZERO_REG != 0) && (wa_a == '0));
  assign w_cmt_b = we_b && ({1'b0, wa_b} < c_DEPTH) && !((ZERO_REG != 0) && (wa_b == '0));

  generate
    for (genvar i = 0; i < DEPTH; i++) begin : g_reg
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_mem[i] <= '0;
        end else if (w_cmt_b && (wa_b == ADDR_W'(i))) begin
          r_mem[i] <= wd_b;
        end else if (w_cmt_a && (wa_a == ADDR_W'(i))) begin
          r_mem[i] <= wd_a;
        end
      end
    end
  endgenerate

  function automatic logic [DATA_W-1:0] f_read(input logic [ADDR_W-1:0] addr);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (addr == ADDR_W'(i)) v = r_mem[i];
    end
    // Port B is checked last so it wins over port A, matching storage priority.
    if (BYPASS != 0) begin
      if (w_cmt_a && (wa_a == addr)) v = wd_a;
      if (w_cmt_b && (wa_b == addr)) v = wd_b;
    end
    if (((ZERO_REG != 0) && (addr == '0)) || ({1'b0, addr} >= c_DEPTH)) v = '0;
    return v;
  endfunction

  always_comb begin
    w_rd1 = f_read(ra1);
    w_rd2 = f_read(ra2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1 <= '0;
      rd2 <= '0;
    end else begin
      if (re1) rd1 <= w_rd1;
      if (re2) rd2 <= w_rd2;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mips_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_regfile_mp
// Brief    : Directed + random bench for three register file configurations.
// Revision : 1.0
// ============================================================================
module tb_mips_regfile_mp;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        re1, re2, we_a, we_b;
  logic [4:0]  ra1, ra2, wa_a, wa_b;
  logic [31:0] wd_a, wd_b;
  logic [31:0] rd1_0, rd2_0, rd1_1, rd2_1, rd1_2, rd2_2;

  int n_pass  = 0;
  int n_total = 0;

  // Instance 0: defaults; 1: no bypass; 2: 16 deep, ordinary register 0.
  int          depth [3] = '{32, 32, 16};
  bit          zr    [3] = '{1'b1, 1'b1, 1'b0};
  bit          byp   [3] = '{1'b1, 1'b0, 1'b1};
  logic [31:0] mm    [3][32];
  logic [31:0] e1    [3];
  logic [31:0] e2    [3];

  always #5 clk = ~clk;

  mips_regfile_mp #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(1)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .re1(re1), .ra1(ra1), .rd1(rd1_0), .re2(re2), .ra2(ra2), .rd2(rd2_0),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b));
  mips_regfile_mp #(.DATA_W(32), .DEPTH(32), .ADDR_W(5), .ZERO_REG(1), .BYPASS(0)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .re1(re1), .ra1(ra1), .rd1(rd1_1), .re2(re2), .ra2(ra2), .rd2(rd2_1),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b));
  mips_regfile_mp #(.DATA_W(32), .DEPTH(16), .ADDR_W(5), .ZERO_REG(0), .BYPASS(1)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .re1(re1), .ra1(ra1), .rd1(rd1_2), .re2(re2), .ra2(ra2), .rd2(rd2_2),
    .we_a(we_a), .wa_a(wa_a), .wd_a(wd_a), .we_b(we_b), .wa_b(wa_b), .wd_b(wd_b));

  function automatic logic [31:0] obs1(input int k);
    return (k == 0) ? rd1_0 : (k == 1) ? rd1_1 : rd1_2;
  endfunction
  function automatic logic [31:0] obs2(input int k);
    return (k == 0) ? rd2_0 : (k == 1) ? rd2_1 : rd2_2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic check_all(input string tag);
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("%s dut%0d rd1", tag, k), obs1(k), e1[k]);
      chk($sformatf("%s dut%0d rd2", tag, k), obs2(k), e2[k]);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 32; a++) mm[k][a] = '0;
      e1[k] = '0;
      e2[k] = '0;
    end
  endtask

  // Build the post-edge array, then read either the new or old image.
  task automatic model_edge();
    logic [31:0] nm [32];
    if (!rst_n) return;
    for (int k = 0; k < 3; k++) begin
      for (int a = 0; a < 32; a++) nm[a] = mm[k][a];
      if (we_a && int'(wa_a) < depth[k] && !(zr[k] && wa_a == 0)) nm[wa_a] = wd_a;
      if (we_b && int'(wa_b) < depth[k] && !(zr[k] && wa_b == 0)) nm[wa_b] = wd_b;
      if (re1) begin
        if (int'(ra1) >= depth[k] || (zr[k] && ra1 == 0)) e1[k] = '0;
        else e1[k] = byp[k] ? nm[ra1] : mm[k][ra1];
      end
      if (re2) begin
        if (int'(ra2) >= depth[k] || (zr[k] && ra2 == 0)) e2[k] = '0;
        else e2[k] = byp[k] ? nm[ra2] : mm[k][ra2];
      end
      for (int a = 0; a < 32; a++) mm[k][a] = nm[a];
    end
  endtask

  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check_all(tag);
  endtask

  task automatic idle();
    re1 = 0; re2 = 0; we_a = 0; we_b = 0;
    ra1 = 0; ra2 = 0; wa_a = 0; wa_b = 0; wd_a = 0; wd_b = 0;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_clear();
    repeat (2) @(posedge clk);
    #1 check_all("reset");
    @(negedge clk) rst_n = 1'b1;

    // Write then read back.
    we_a = 1; wa_a = 5; wd_a = 32'hDEADBEEF;
    cycle("wr5");
    idle(); re1 = 1; ra1 = 5;
    cycle("rd5");
    chk("rd5 value", rd1_0, 32'hDEADBEEF);

    // Dual write to one address, same-edge read.
    idle();
    we_a = 1; wa_a = 7; wd_a = 32'h11;
    we_b = 1; wa_b = 7; wd_b = 32'h22;
    re1 = 1; ra1 = 7;
    cycle("ww7");
    chk("ww7 bypass", rd1_0, 32'h22);
    chk("ww7 nobypass", rd1_1, 32'h0);
    idle(); re1 = 1; ra1 = 7;
    cycle("rd7");
    chk("rd7 portB wins", rd1_1, 32'h22);

    // Zero register write is never forwarded or stored.
    idle(); we_b = 1; wa_b = 0; wd_b = 32'hFFFFFFFF; re2 = 1; ra2 = 0;
    cycle("wr0");
    chk("wr0 no forward", rd2_0, 32'h0);
    chk("wr0 ordinary reg0", rd2_2, 32'hFFFFFFFF);
    idle(); re2 = 1; ra2 = 0;
    cycle("rd0");
    chk("rd0 zero", rd2_0, 32'h0);

    // Collision read with and without bypass, then read-enable hold.
    idle(); we_a = 1; wa_a = 3; wd_a = 32'hA5;
    cycle("wr3");
    idle(); we_a = 1; wa_a = 3; wd_a = 32'h5A; re1 = 1; ra1 = 3;
    cycle("col3");
    chk("col3 nobypass", rd1_1, 32'hA5);
    chk("col3 bypass", rd1_0, 32'h5A);
    idle(); we_a = 1; wa_a = 3; wd_a = 32'h77; re1 = 0; ra1 = 3;
    cycle("hold3");
    chk("hold3", rd1_0, 32'h5A);

    // Out-of-range write on the 16-deep instance.
    idle(); we_a = 1; wa_a = 20; wd_a = 32'h33;
    cycle("wr20");
    idle(); re1 = 1; ra1 = 20;
    cycle("rd20");
    chk("rd20 dropped", rd1_2, 32'h0);
    chk("rd20 stored", rd1_0, 32'h33);

    // Fill 1..31 with index, then an asynchronous mid-cycle reset.
    for (int a = 1; a < 32; a += 2) begin
      idle();
      we_a = 1; wa_a = 5'(a); wd_a = 32'(a);
      if (a + 1 < 32) begin we_b = 1; wa_b = 5'(a + 1); wd_b = 32'(a + 1); end
      cycle("fill");
    end
    idle(); re1 = 1; ra1 = 1; re2 = 1; ra2 = 31;
    cycle("prerst");
    chk("prerst rd2", rd2_0, 32'd31);
    #3 rst_n = 1'b0;
    model_clear();
    #1 check_all("async rst");
    we_a = 1; wa_a = 9; wd_a = 32'h1234; re1 = 1; ra1 = 9;
    cycle("in rst");
    @(negedge clk) rst_n = 1'b1;
    for (int a = 0; a < 32; a++) begin
      idle(); re1 = 1; ra1 = 5'(a); re2 = 1; ra2 = 5'(31 - a);
      cycle("post rst");
    end

    // Randomised traffic biased toward address collisions.
    for (int n = 0; n < 400; n++) begin
      we_a = 1'($urandom_range(0, 1));
      we_b = 1'($urandom_range(0, 1));
      wa_a = ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom_range(0, 31));
      wa_b = ($urandom_range(0, 2) == 0) ? wa_a : 5'($urandom_range(0, 31));
      wd_a = $urandom;
      wd_b = $urandom;
      re1  = ($urandom_range(0, 3) != 0);
      re2  = ($urandom_range(0, 3) != 0);
      ra1  = ($urandom_range(0, 1) == 0) ? wa_a : 5'($urandom_range(0, 31));
      ra2  = ($urandom_range(0, 1) == 0) ? wa_b : 5'($urandom_range(0, 31));
      cycle("rand");
    end

    for (int a = 0; a < 32; a++) begin
      idle(); re1 = 1; ra1 = 5'(a); re2 = 1; ra2 = 5'(a);
      cycle("readback");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
